// File: rtl/vga_pkg.sv
// Shared VGA definitions for the caption renderers.
// Contents:
//   H_ACTIVE, V_ACTIVE : visible raster size in pixels / lines
//   rgb_t              : 4:4:4 colour word
//   WHITE, BLACK       : colour constants
//   state_t            : renderer FSM states
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [11:0] rgb_t;

  localparam rgb_t WHITE = 12'hFFF;
  localparam rgb_t BLACK = 12'h000;

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/scorename_renderer_glyph_shifter.sv
// glyph_shifter: holds one glyph row and walks it MSB-first.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture data_i, restart bit and scale counters
//   shift_i   : one pixel tick of progress (scale count, then shift)
//   clear_i   : drop the row (abort); wins over load and shift
//   data_i    : row bitmap, bit COLS-1 is leftmost
//   bit_o     : current pixel bit
//   done_o    : last tick of the last bit is in progress
module glyph_shifter #(
  parameter int COLS    = 44,
  parameter int H_SCALE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic            clear_i,
  input  logic [COLS-1:0] data_i,
  output logic            bit_o,
  output logic            done_o
);

  localparam int BW = $clog2(COLS);
  localparam logic [BW-1:0] LAST_BIT = BW'(COLS - 1);
  localparam logic [1:0]    LAST_SC  = 2'(H_SCALE - 1);

  logic [COLS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [1:0]      scnt_q, scnt_d;

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    scnt_d   = scnt_q;
    if (clear_i) begin
      shreg_d  = '0;
      bitcnt_d = '0;
      scnt_d   = '0;
    end else if (load_i) begin
      shreg_d  = data_i;
      bitcnt_d = '0;
      scnt_d   = '0;
    end else if (shift_i) begin
      if (scnt_q == LAST_SC) begin
        scnt_d   = '0;
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      scnt_q   <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  assign bit_o  = shreg_q[COLS-1];
  assign done_o = (bitcnt_q == LAST_BIT) && (scnt_q == LAST_SC);

endmodule

// File: rtl/scorename_renderer.sv
// scorename_renderer: draws the "SCORE" caption from the glyph ROM.
// The row for the current line is captured one pixel before X0, then
// shifted out MSB-first, each bit held H_SCALE pixel ticks. Outputs are
// registered, so the pixel for column X0+k appears the tick after hc==X0+k.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   pix_en     : pixel tick qualifier
//   video_on   : active video; low during SHIFT aborts the row
//   hc, vc     : raster counters
//   rom_vc     : ROM row address (combinational copy of vc)
//   rom_data   : ROM row, bits COLS-1..0 used
//   text_on    : caption pixel lit
//   text_rgb   : FG when lit, else BG
//   busy       : FSM is in SHIFT (doubles as the state debug view)
module scorename_renderer
  import vga_pkg::*;
#(
  parameter int   X0      = 200,
  parameter int   Y0      = 100,
  parameter int   ROWS    = 16,
  parameter int   COLS    = 44,
  parameter int   H_SCALE = 1,
  parameter rgb_t FG      = WHITE,
  parameter rgb_t BG      = BLACK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        video_on,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  output logic [10:0] rom_vc,
  input  logic [46:0] rom_data,
  output logic        text_on,
  output logic [11:0] text_rgb,
  output logic        busy
);

  localparam logic [10:0] Y_LO    = 11'(Y0);
  localparam logic [10:0] Y_HI    = 11'(Y0 + ROWS);
  localparam logic [10:0] LOAD_HC = 11'(X0 - 1);

  state_t      state_q, state_d;
  logic        text_on_q, text_on_d;
  logic [11:0] text_rgb_q, text_rgb_d;
  logic        in_win;
  logic        ld, sh, clr;
  logic        cur_bit, done;

  generate
    if (COLS < 47) begin : g_unused_hi
      logic unused_rom_hi;
      assign unused_rom_hi = ^rom_data[46:COLS];
    end
  endgenerate

  assign rom_vc = vc;
  assign in_win = (vc >= Y_LO) && (vc < Y_HI);

  glyph_shifter #(
    .COLS    (COLS),
    .H_SCALE (H_SCALE)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .shift_i (sh),
    .clear_i (clr),
    .data_i  (rom_data[COLS-1:0]),
    .bit_o   (cur_bit),
    .done_o  (done)
  );

  always_comb begin
    state_d    = state_q;
    ld         = 1'b0;
    sh         = 1'b0;
    clr        = 1'b0;
    text_on_d  = text_on_q;
    text_rgb_d = text_rgb_q;
    case (state_q)
      IDLE: begin
        if (pix_en && in_win && (hc == LOAD_HC)) begin
          ld      = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (pix_en) begin
          if (!video_on) begin
            clr     = 1'b1;
            state_d = IDLE;
          end else begin
            sh = 1'b1;
            if (done) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Output reflects the state/bit before this tick's update: one tick latency.
    if (pix_en) begin
      text_on_d  = (state_q == SHIFT) && cur_bit && video_on;
      text_rgb_d = text_on_d ? FG : BG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      text_on_q  <= 1'b0;
      text_rgb_q <= BG;
    end else begin
      state_q    <= state_d;
      text_on_q  <= text_on_d;
      text_rgb_q <= text_rgb_d;
    end
  end

  assign text_on  = text_on_q;
  assign text_rgb = text_rgb_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_scorename_renderer.sv
// Directed bench for scorename_renderer: one instance with H_SCALE=1 and
// one with H_SCALE=2 share the raster inputs; each has its own ROM model.
module tb_scorename_renderer;

  localparam logic [43:0] ROW2 = 44'hFE7F0E1FCFE;
  localparam logic [43:0] ROW6 = 44'h80F0F0F0F01;
  localparam logic [43:0] ONES = {44{1'b1}};

  logic        clk = 1'b0;
  logic        rst, pix_en, video_on;
  logic [10:0] hc, vc;
  logic [10:0] rom_vc1, rom_vc2;
  logic [46:0] rom_data1, rom_data2;
  logic        on1, on2, busy1, busy2;
  logic [11:0] rgb1, rgb2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // ROM model; bits 46..44 carry junk that must be ignored.
  function automatic logic [46:0] rom_row(input logic [10:0] v);
    case (v)
      11'd99, 11'd116:  rom_row = {47{1'b1}};
      11'd100, 11'd101, 11'd112, 11'd113, 11'd114, 11'd115:
                        rom_row = {3'b111, 44'h0};
      11'd102:          rom_row = {3'b101, ROW2};
      11'd104, 11'd105: rom_row = {3'b101, ONES};
      11'd106:          rom_row = {3'b101, ROW6};
      default:          rom_row = 47'h0;
    endcase
  endfunction

  always_comb rom_data1 = rom_row(rom_vc1);
  always_comb rom_data2 = rom_row(rom_vc2);

  scorename_renderer #(.H_SCALE(1)) u_h1 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .video_on(video_on),
    .hc(hc), .vc(vc), .rom_vc(rom_vc1), .rom_data(rom_data1),
    .text_on(on1), .text_rgb(rgb1), .busy(busy1)
  );

  scorename_renderer #(.H_SCALE(2)) u_h2 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .video_on(video_on),
    .hc(hc), .vc(vc), .rom_vc(rom_vc2), .rom_data(rom_data2),
    .text_on(on2), .text_rgb(rgb2), .busy(busy2)
  );

  // One pixel: a pix_en clock followed by a hold clock, sampled 1ns later.
  task automatic drive_pix(input logic [10:0] h, input logic [10:0] v, input logic vid);
    @(negedge clk);
    hc = h; vc = v; video_on = vid; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      pix_en = ~pix_en;
    end
    @(posedge clk);
    #1;
    total_cnt++; if (on1 !== 1'b0) $display("FAIL reset_on1 got=%b exp=0", on1); else pass_cnt++;
    total_cnt++; if (rgb1 !== 12'h000) $display("FAIL reset_rgb1 got=%h exp=000", rgb1); else pass_cnt++;
    total_cnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got=%b exp=0", busy1); else pass_cnt++;
    total_cnt++; if (on2 !== 1'b0) $display("FAIL reset_on2 got=%b exp=0", on2); else pass_cnt++;
    total_cnt++; if (rgb2 !== 12'h000) $display("FAIL reset_rgb2 got=%h exp=000", rgb2); else pass_cnt++;
    total_cnt++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got=%b exp=0", busy2); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0;
  endtask

  task automatic test_row2();
    logic        exp_on, exp_busy;
    logic [11:0] exp_rgb;
    for (int h = 198; h <= 300; h++) begin
      drive_pix(11'(h), 11'd102, 1'b1);
      exp_on   = (h >= 200 && h <= 243) ? ROW2[43 - (h - 200)] : 1'b0;
      exp_rgb  = exp_on ? 12'hFFF : 12'h000;
      exp_busy = (h >= 199 && h <= 242);
      total_cnt++; if (on1 !== exp_on) $display("FAIL row2_on hc=%0d got=%b exp=%b", h, on1, exp_on); else pass_cnt++;
      total_cnt++; if (rgb1 !== exp_rgb) $display("FAIL row2_rgb hc=%0d got=%h exp=%h", h, rgb1, exp_rgb); else pass_cnt++;
      total_cnt++; if (busy1 !== exp_busy) $display("FAIL row2_busy hc=%0d got=%b exp=%b", h, busy1, exp_busy); else pass_cnt++;
    end
    total_cnt++; if (rom_vc1 !== 11'd102) $display("FAIL rom_vc got=%0d exp=102", rom_vc1); else pass_cnt++;
  endtask

  task automatic test_blank();
    int blank_v[6] = '{100, 101, 112, 113, 114, 115};
    int b1, b2, lit;
    foreach (blank_v[i]) begin
      b1 = 0; b2 = 0; lit = 0;
      for (int h = 198; h <= 300; h++) begin
        drive_pix(11'(h), 11'(blank_v[i]), 1'b1);
        if (busy1) b1++;
        if (busy2) b2++;
        if (on1 || on2 || rgb1 != 12'h000 || rgb2 != 12'h000) lit++;
      end
      total_cnt++; if (lit !== 0) $display("FAIL blank_lit vc=%0d got=%0d exp=0", blank_v[i], lit); else pass_cnt++;
      total_cnt++; if (b1 !== 44) $display("FAIL blank_busy1 vc=%0d got=%0d exp=44", blank_v[i], b1); else pass_cnt++;
      total_cnt++; if (b2 !== 88) $display("FAIL blank_busy2 vc=%0d got=%0d exp=88", blank_v[i], b2); else pass_cnt++;
    end
  endtask

  task automatic test_out_of_window();
    int out_v[2] = '{99, 116};
    int b, lit;
    foreach (out_v[i]) begin
      b = 0; lit = 0;
      for (int h = 198; h <= 300; h++) begin
        drive_pix(11'(h), 11'(out_v[i]), 1'b1);
        if (busy1 || busy2) b++;
        if (on1 || on2) lit++;
      end
      total_cnt++; if (b !== 0) $display("FAIL oow_busy vc=%0d got=%0d exp=0", out_v[i], b); else pass_cnt++;
      total_cnt++; if (lit !== 0) $display("FAIL oow_lit vc=%0d got=%0d exp=0", out_v[i], lit); else pass_cnt++;
    end
  endtask

  task automatic test_hscale2();
    logic exp_on, exp_busy;
    for (int h = 198; h <= 300; h++) begin
      drive_pix(11'(h), 11'd106, 1'b1);
      exp_on   = (h >= 200 && h <= 287) ? ROW6[43 - (h - 200) / 2] : 1'b0;
      exp_busy = (h >= 199 && h <= 286);
      total_cnt++; if (on2 !== exp_on) $display("FAIL h2_on hc=%0d got=%b exp=%b", h, on2, exp_on); else pass_cnt++;
      total_cnt++; if (busy2 !== exp_busy) $display("FAIL h2_busy hc=%0d got=%b exp=%b", h, busy2, exp_busy); else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    logic exp_on;
    for (int h = 198; h <= 300; h++) begin
      drive_pix(11'(h), 11'd104, (h < 220));
      exp_on = (h >= 200 && h <= 219);
      total_cnt++; if (on1 !== exp_on) $display("FAIL abort_on1 hc=%0d got=%b exp=%b", h, on1, exp_on); else pass_cnt++;
      total_cnt++; if (on2 !== exp_on) $display("FAIL abort_on2 hc=%0d got=%b exp=%b", h, on2, exp_on); else pass_cnt++;
      total_cnt++; if (busy1 !== (h >= 199 && h <= 219)) $display("FAIL abort_busy1 hc=%0d got=%b", h, busy1); else pass_cnt++;
      total_cnt++; if (busy2 !== (h >= 199 && h <= 219)) $display("FAIL abort_busy2 hc=%0d got=%b", h, busy2); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int b, lit;
    for (int h = 198; h <= 209; h++) begin
      drive_pix(11'(h), 11'd105, 1'b1);
      total_cnt++; if (on1 !== (h >= 200)) $display("FAIL rmid_pre_on1 hc=%0d got=%b", h, on1); else pass_cnt++;
      total_cnt++; if (on2 !== (h >= 200)) $display("FAIL rmid_pre_on2 hc=%0d got=%b", h, on2); else pass_cnt++;
    end
    @(negedge clk);
    hc = 11'd210; vc = 11'd105; video_on = 1'b1; pix_en = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if (on1 !== 1'b0) $display("FAIL rmid_on1 got=%b exp=0", on1); else pass_cnt++;
    total_cnt++; if (rgb1 !== 12'h000) $display("FAIL rmid_rgb1 got=%h exp=000", rgb1); else pass_cnt++;
    total_cnt++; if (busy1 !== 1'b0) $display("FAIL rmid_busy1 got=%b exp=0", busy1); else pass_cnt++;
    total_cnt++; if (on2 !== 1'b0) $display("FAIL rmid_on2 got=%b exp=0", on2); else pass_cnt++;
    total_cnt++; if (busy2 !== 1'b0) $display("FAIL rmid_busy2 got=%b exp=0", busy2); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0;
    b = 0; lit = 0;
    for (int h = 211; h <= 300; h++) begin
      drive_pix(11'(h), 11'd105, 1'b1);
      if (busy1 || busy2) b++;
      if (on1 || on2) lit++;
    end
    total_cnt++; if (b !== 0) $display("FAIL rmid_post_busy got=%0d exp=0", b); else pass_cnt++;
    total_cnt++; if (lit !== 0) $display("FAIL rmid_post_lit got=%0d exp=0", lit); else pass_cnt++;
  endtask

  task automatic test_resume();
    logic        exp_on;
    logic [11:0] exp_rgb;
    for (int h = 198; h <= 300; h++) begin
      drive_pix(11'(h), 11'd106, 1'b1);
      exp_on  = (h >= 200 && h <= 243) ? ROW6[43 - (h - 200)] : 1'b0;
      exp_rgb = exp_on ? 12'hFFF : 12'h000;
      total_cnt++; if (on1 !== exp_on) $display("FAIL resume_on hc=%0d got=%b exp=%b", h, on1, exp_on); else pass_cnt++;
      total_cnt++; if (rgb1 !== exp_rgb) $display("FAIL resume_rgb hc=%0d got=%h exp=%h", h, rgb1, exp_rgb); else pass_cnt++;
      total_cnt++; if (busy1 !== (h >= 199 && h <= 242)) $display("FAIL resume_busy hc=%0d got=%b", h, busy1); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; video_on = 1'b1; hc = '0; vc = '0;
    test_reset();
    test_row2();
    test_blank();
    test_out_of_window();
    test_hscale2();
    test_abort();
    test_reset_mid();
    test_resume();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
